mem_bus_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port instruction/data Memory (CS, WE, 7-bit ADDR, 32-bit shared bus; Memory samples on negedge CLK).
- Port 0 is the MIPS core. Port 1 is a secondary master: program loader, LED/debug reader or DMA.
- Converts each requester's req/ack handshake into a one-cycle memory access and returns read data.
- Keeps all bus tristating at the top level via an explicit write-data output-enable.

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS instruction/data memory bus slice.
package mips_mem_pkg;

    localparam int MEM_AW = 7;
    localparam int MEM_DW = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU port and the auxiliary port.
// MEM_BUS_ARBITER_RR_EN selects round-robin; otherwise fixed priority to port 0.
module mem_arb_pick
    import mips_mem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_rr_ptr,
    output logic       o_valid,
    output logic       o_port
);

    assign o_valid = |i_req;

`ifdef MEM_BUS_ARBITER_RR_EN
    always_comb begin
        if (i_req[0] && i_req[1]) o_port = i_rr_ptr;
        else if (i_req[1])        o_port = PORT_AUX;
        else                      o_port = PORT_CPU;
    end
`else
    logic w_unused_rr_ptr;
    assign w_unused_rr_ptr = i_rr_ptr;

    // Port 1 only wins when port 0 is silent.
    assign o_port = (!i_req[0] && i_req[1]) ? PORT_AUX : PORT_CPU;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port req/ack arbiter and sequencer for the single-port MIPS memory.
// Define MEM_BUS_ARBITER_RR_EN for round-robin arbitration instead of port-0 priority.
module mem_bus_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wdata_oe,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    mem_state_t    r_state, w_next_state;
    logic          r_port, r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_m0_rdata, r_m1_rdata;
    logic          w_rr_ptr, w_grant_valid, w_grant_port, w_grant;

    mem_arb_pick u_pick (
        .i_req    ({m1_req, m0_req}),
        .i_rr_ptr (w_rr_ptr),
        .o_valid  (w_grant_valid),
        .o_port   (w_grant_port)
    );

    assign w_grant = (r_state == IDLE) && w_grant_valid;

`ifdef MEM_BUS_ARBITER_RR_EN
    logic r_rr_ptr;

    always_ff @(posedge CLK) begin
        if (RST)          r_rr_ptr <= 1'b0;
        else if (w_grant) r_rr_ptr <= ~r_rr_ptr;
    end

    assign w_rr_ptr = r_rr_ptr;
`else
    assign w_rr_ptr = 1'b0;
`endif

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:    w_next_state = w_grant_valid ? ACCESS : IDLE;
            ACCESS:  w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case, so no latch is inferred.
    always_comb begin
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_wdata_oe = 1'b0;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        case (r_state)
            ACCESS: begin
                mem_cs       = 1'b1;
                mem_we       = r_we;
                mem_wdata_oe = r_we;
            end
            DONE: begin
                m0_ack = (r_port == PORT_CPU);
                m1_ack = (r_port == PORT_AUX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_port  <= PORT_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_port  <= w_grant_port;
            r_we    <= (w_grant_port == PORT_AUX) ? m1_we    : m0_we;
            r_addr  <= (w_grant_port == PORT_AUX) ? m1_addr  : m0_addr;
            r_wdata <= (w_grant_port == PORT_AUX) ? m1_wdata : m0_wdata;
        end
    end

    // Read data is captured at the posedge closing ACCESS; reset aborts the capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if (r_state == ACCESS && !r_we) begin
            if (r_port == PORT_AUX) r_m1_rdata <= mem_rdata;
            else                    r_m0_rdata <= mem_rdata;
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: transaction-level reference model plus a memory model.
// Honours MEM_BUS_ARBITER_RR_EN to predict round-robin or fixed-priority grant order.
module tb_mem_bus_arbiter;
    import mips_mem_pkg::*;

    localparam int AW = MEM_AW;
    localparam int DW = MEM_DW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [AW-1:0] m0_addr, m1_addr, mem_addr;
    logic [DW-1:0] m0_wdata, m0_rdata, m1_wdata, m1_rdata;
    logic          mem_cs, mem_we, mem_wdata_oe, busy;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 CLK = ~CLK;

    mem_bus_arbiter dut (
        .CLK(CLK), .RST(RST),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory device on the shared bus, sampling on negedge.
    logic [DW-1:0] mem [0:127];
    logic [DW-1:0] mem_q = '0;
    assign mem_rdata = mem_wdata_oe ? mem_wdata : mem_q;

    always @(negedge CLK) begin
        if (mem_cs) begin
            if (mem_we) mem[mem_addr] = mem_rdata;
            else        mem_q = mem[mem_addr];
        end
    end

    // Transaction-level reference model.
    typedef struct {
        logic          port;
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] ref_mem [0:127];
    logic [DW-1:0] exp_rdata [2];
    logic          model_ptr;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic both_winner();
`ifdef MEM_BUS_ARBITER_RR_EN
        return model_ptr;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        model_ptr    = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic model_issue(input logic p, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
        exp_t e;
        e.port = p;
        e.rd   = !we;
        e.data = we ? '0 : ref_mem[a];
        if (we) ref_mem[a] = d;
        exp_q.push_back(e);
        model_ptr = ~model_ptr;
    endtask

    // Monitor: every ack pops one expected transaction.
    always @(negedge CLK) begin
        if (!RST && (m0_ack || m1_ack)) begin
            check("ack_exclusive", {63'd0, m0_ack & m1_ack}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {62'd0, m1_ack, m0_ack}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_port", {63'd0, m1_ack}, {63'd0, mon_e.port});
                if (mon_e.rd) exp_rdata[mon_e.port] = mon_e.data;
                check("m0_rdata", m0_rdata, exp_rdata[0]);
                check("m1_rdata", m1_rdata, exp_rdata[1]);
            end
        end
    end

    task automatic drive(input logic p, input logic rq, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d; end
        else   begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d; end
    endtask

    task automatic drive_req(input logic p, input logic rq);
        if (p) m1_req = rq;
        else   m0_req = rq;
    endtask

    // One isolated transaction with cycle-exact timing checks.
    task automatic single(input logic p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic pulse_other);
        model_issue(p, we, a, d);
        @(posedge CLK); #1;
        drive(p, 1'b1, we, a, d);
        @(posedge CLK); #1;
        check("cs_in_access", {63'd0, mem_cs}, 64'd1);
        check("addr_in_access", {57'd0, mem_addr}, {57'd0, a});
        check("we_in_access", {63'd0, mem_we}, {63'd0, we});
        check("oe_in_access", {63'd0, mem_wdata_oe}, {63'd0, we});
        if (we) check("wdata_in_access", {32'd0, mem_wdata}, {32'd0, d});
        if (pulse_other) drive_req(~p, 1'b1);
        @(posedge CLK); #1;
        check("ack_latency", {63'd0, p ? m1_ack : m0_ack}, 64'd1);
        check("cs_in_done", {62'd0, mem_cs, mem_wdata_oe}, 64'd0);
        drive_req(p, 1'b0);
        if (pulse_other) drive_req(~p, 1'b0);
    endtask

    // Random round: one or both ports request at once and hold until acked.
    task automatic do_round();
        logic          use_p [2];
        logic          we_p  [2];
        logic [AW-1:0] a_p   [2];
        logic [DW-1:0] d_p   [2];
        logic          first;
        logic          pend  [2];
        for (int i = 0; i < 2; i++) begin
            use_p[i] = 1'($urandom_range(0, 1));
            we_p[i]  = 1'($urandom_range(0, 1));
            a_p[i]   = AW'($urandom_range(0, 15));
            d_p[i]   = $urandom;
        end
        if (!use_p[0] && !use_p[1]) use_p[1] = 1'b1;
        first = (use_p[0] && use_p[1]) ? both_winner() : use_p[1];
        model_issue(first, we_p[first], a_p[first], d_p[first]);
        if (use_p[0] && use_p[1]) model_issue(~first, we_p[~first], a_p[~first], d_p[~first]);
        repeat ($urandom_range(0, 2)) @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            pend[i] = use_p[i];
            if (use_p[i]) drive(1'(i), 1'b1, we_p[i], a_p[i], d_p[i]);
        end
        for (int k = 0; k < 20 && (pend[0] || pend[1]); k++) begin
            @(posedge CLK); #1;
            if (m0_ack) begin m0_req = 1'b0; pend[0] = 1'b0; end
            if (m1_ack) begin m1_req = 1'b0; pend[1] = 1'b0; end
        end
        if (pend[0] || pend[1]) begin
            check("round_timeout", {62'd0, pend[1], pend[0]}, 64'd0);
            m0_req = 1'b0;
            m1_req = 1'b0;
        end
    endtask

    initial begin
        int n, last;
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 128; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5]     = 32'h00412022;
        ref_mem[5] = 32'h00412022;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_acks", {62'd0, m1_ack, m0_ack}, 64'd0);
        check("rst_mem_ctl", {61'd0, mem_cs, mem_we, mem_wdata_oe}, 64'd0);
        check("rst_mem_addr", {57'd0, mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
        RST = 1'b0;

        // Single read, then write-then-read on port 1.
        single(1'b0, 1'b0, 7'd5, '0, 1'b0);
        single(1'b1, 1'b1, 7'd100, 32'h00000120, 1'b0);
        single(1'b1, 1'b0, 7'd100, '0, 1'b0);

        // Both ports hold req continuously.
        for (int k = 0; k < 6; k++) begin
            logic w;
            w = both_winner();
            model_issue(w, 1'b0, w ? 7'd100 : 7'd5, '0);
        end
        model_issue(1'b1, 1'b0, 7'd100, '0);
        @(posedge CLK); #1;
        drive(1'b0, 1'b1, 1'b0, 7'd5, '0);
        drive(1'b1, 1'b1, 1'b0, 7'd100, '0);
        n = 0;
        last = 0;
        for (int k = 0; k < 60 && n < 7; k++) begin
            @(posedge CLK); #1;
            if (m0_ack || m1_ack) begin
                if (n > 0 && n < 6) check("ack_spacing", 64'(cyc - last), 64'd3);
                last = cyc;
                n++;
                if (n == 6) m0_req = 1'b0;
                if (n == 7) m1_req = 1'b0;
            end
        end
        check("hold_ack_count", 64'(n), 64'd7);
        m0_req = 1'b0;
        m1_req = 1'b0;

        // Reset during ACCESS of a port-0 read of address 3.
        @(posedge CLK); #1;
        drive(1'b0, 1'b1, 1'b0, 7'd3, '0);
        @(posedge CLK); #1;
        check("abort_in_access", {63'd0, mem_cs}, 64'd1);
        RST = 1'b1;
        model_reset();
        @(posedge CLK); #1;
        check("abort_idle", {63'd0, busy}, 64'd0);
        check("abort_no_ack", {62'd0, m1_ack, m0_ack}, 64'd0);
        check("abort_rdata", {32'd0, m0_rdata}, 64'd0);
        drive_req(1'b0, 1'b0);
        RST = 1'b0;
        single(1'b0, 1'b0, 7'd3, '0, 1'b0);

        // Port 1 request pulsed only while port 0 holds the grant.
        single(1'b0, 1'b0, 7'd5, '0, 1'b1);
        @(posedge CLK); #1;
        check("withdrawn_idle", {63'd0, busy}, 64'd0);
        @(posedge CLK); #1;
        check("withdrawn_stays_idle", {63'd0, busy}, 64'd0);

        for (int r = 0; r < 40; r++) do_round();

        repeat (4) @(posedge CLK);
        #1;
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        check("final_busy", {63'd0, busy}, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
